exchange_test: RTL and testbench

- Produces the per-pair replica-exchange decision bit for pair (id, id+1).
- Its output feeds replica id's folw_exchange and replica id+1's prev_exchange.
- Runs a Metropolis test: accept iff dbeta*(E_self-E_folw) + rnd_log >= 0, with rnd_log = -ln(u) in the same fixed point as dbeta.
- Uses a serial shift-add multiplier to keep area small, since one instance exists per replica.

---
 rtl/exchange_test.sv | 158 +++++++++++++++
 tb/tb_exchange_test.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/exchange_test.sv
// Replica-exchange Metropolis decision for the pair (id, id+1).
// Accepts the swap when dbeta*(E_self - E_folw) + rnd_log >= 0, using a
// serial shift-add multiplier so each replica's instance stays small.
module exchange_test #(
    parameter int unsigned id          = 0,
    parameter int unsigned replica_num = 32,
    parameter int unsigned E_W         = 24,
    parameter int unsigned B_W         = 17,
    parameter int unsigned R_W         = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [E_W-1:0] self_energy,
    input  logic [E_W-1:0] folw_energy,
    input  logic           dbeta_neg,
    input  logic [B_W-1:0] dbeta_mag,
    input  logic [R_W-1:0] rnd_log,
    input  logic           cnt_clr,
    output logic           busy,
    output logic           done,
    output logic           exchange,
    output logic [15:0]    accept_cnt
);

    localparam int unsigned ACC_W = E_W + B_W;
    localparam int unsigned P_W   = ACC_W + 1;
    localparam int unsigned S_W   = ACC_W + 2;
    localparam int unsigned CNT_W = $clog2(B_W);
    localparam bit          PARTNER = (id != replica_num - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_CMP
    } state_t;

    state_t             state_q;
    logic [E_W-1:0]     self_q;
    logic [E_W-1:0]     folw_q;
    logic               neg_q;
    logic [B_W-1:0]     mag_q;
    logic [R_W-1:0]     rnd_q;
    logic               sign_q;
    logic [ACC_W-1:0]   mcand_q;
    logic [B_W-1:0]     mplier_q;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   bitcnt_q;
    logic               busy_q;
    logic               done_q;
    logic               exch_q;
    logic [15:0]        cnt_q;

    logic [E_W:0]            diff_c;
    logic [E_W-1:0]          absd_c;
    logic [ACC_W-1:0]        acc_add_c;
    logic signed [P_W-1:0]   prod_c;
    logic signed [S_W-1:0]   sum_c;
    logic                    accept_c;

    // Energy difference, next partial product and the final Metropolis sum
    always_comb begin
        diff_c    = {1'b0, self_q} - {1'b0, folw_q};
        absd_c    = diff_c[E_W] ? E_W'(-diff_c) : diff_c[E_W-1:0];
        acc_add_c = acc_q + (mplier_q[0] ? mcand_q : ACC_W'(0));
        // A zero product is always taken as positive
        prod_c    = (sign_q && (acc_q != ACC_W'(0))) ? -$signed({1'b0, acc_q})
                                                     :  $signed({1'b0, acc_q});
        sum_c     = $signed({prod_c[P_W-1], prod_c}) + $signed(S_W'(rnd_q));
        accept_c  = (sum_c >= $signed(S_W'(0))) && PARTNER;
    end

    // Control FSM, serial multiplier datapath and acceptance counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            self_q   <= '0;
            folw_q   <= '0;
            neg_q    <= 1'b0;
            mag_q    <= '0;
            rnd_q    <= '0;
            sign_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            exch_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;

            // Clear beats a same-cycle increment
            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (state_q == S_CMP && !abort && accept_c && cnt_q != 16'hFFFF) begin
                cnt_q <= cnt_q + 16'd1;
            end

            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                exch_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            self_q  <= self_energy;
                            folw_q  <= folw_energy;
                            neg_q   <= dbeta_neg;
                            mag_q   <= dbeta_mag;
                            rnd_q   <= rnd_log;
                            exch_q  <= 1'b0;
                            busy_q  <= 1'b1;
                            state_q <= S_LOAD;
                        end
                    end
                    S_LOAD: begin
                        sign_q   <= neg_q ^ diff_c[E_W];
                        mcand_q  <= ACC_W'(absd_c);
                        mplier_q <= mag_q;
                        acc_q    <= '0;
                        bitcnt_q <= CNT_W'(B_W - 1);
                        state_q  <= S_MUL;
                    end
                    S_MUL: begin
                        acc_q    <= acc_add_c;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        bitcnt_q <= bitcnt_q - CNT_W'(1);
                        if (bitcnt_q == CNT_W'(0)) begin
                            state_q <= S_CMP;
                        end
                    end
                    S_CMP: begin
                        exch_q  <= accept_c;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign exchange   = exch_q;
    assign accept_cnt = cnt_q;

endmodule

// File: tb/tb_exchange_test.sv
// Bench for exchange_test: a paired instance (id 0) and a partnerless one (id 31).
module tb_exchange_test;

    typedef struct {
        logic [23:0] self_e;
        logic [23:0] folw_e;
        logic        neg;
        logic [16:0] mag;
        logic [23:0] rnd;
        logic        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        cnt_clr = 1'b0;
    logic [23:0] self_e = '0;
    logic [23:0] folw_e = '0;
    logic        dneg = 1'b0;
    logic [16:0] dmag = '0;
    logic [23:0] rnd = '0;

    logic        busy0, done0, exchange0;
    logic [15:0] cnt0;
    logic        busy31, done31, exchange31;
    logic [15:0] cnt31;

    int checks = 0;
    int errors = 0;
    longint cnt_model = 0;

    exchange_test #(.id(0)) dut0 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .self_energy(self_e), .folw_energy(folw_e), .dbeta_neg(dneg),
        .dbeta_mag(dmag), .rnd_log(rnd), .busy(busy0), .done(done0),
        .exchange(exchange0), .accept_cnt(cnt0), .cnt_clr(cnt_clr)
    );

    exchange_test #(.id(31)) dut31 (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .self_energy(self_e), .folw_energy(folw_e), .dbeta_neg(dneg),
        .dbeta_mag(dmag), .rnd_log(rnd), .busy(busy31), .done(done31),
        .exchange(exchange31), .accept_cnt(cnt31), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Metropolis rule in plain integer arithmetic
    function automatic bit model(input vec_t v, input bit partner);
        longint d;
        longint p;
        d = longint'(v.self_e) - longint'(v.folw_e);
        p = d * longint'(v.mag);
        if (v.neg) p = -p;
        return partner && ((p + longint'(v.rnd)) >= 0);
    endfunction

    function automatic longint sat(input longint c);
        return (c > 65535) ? 65535 : c;
    endfunction

    task automatic apply(input vec_t v);
        self_e = v.self_e;
        folw_e = v.folw_e;
        dneg   = v.neg;
        dmag   = v.mag;
        rnd    = v.rnd;
    endtask

    // One request; start held for 'hold' sampled edges; watches 40 edges
    task automatic run(input vec_t v, input int hold,
                       output int lat0, output logic ex0, output int nd0,
                       output int lat31, output logic ex31);
        @(negedge clk);
        apply(v);
        start = 1'b1;
        lat0 = -1; lat31 = -1; ex0 = 1'b0; ex31 = 1'b0; nd0 = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (n == hold - 1) start = 1'b0;
            if (done0) begin
                nd0++;
                if (lat0 < 0) begin lat0 = n; ex0 = exchange0; end
            end
            if (done31 && lat31 < 0) begin lat31 = n; ex31 = exchange31; end
        end
    endtask

    task automatic run_check(input string name, input vec_t v);
        int l0, l31, nd;
        logic e0, e31;
        bit   m;
        run(v, 1, l0, e0, nd, l31, e31);
        m = model(v, 1'b1);
        cnt_model = sat(cnt_model + (m ? 1 : 0));
        chk({name, "_lat0"}, l0, 19);
        chk({name, "_exch0"}, e0, v.exp);
        chk({name, "_model0"}, e0, m);
        chk({name, "_lat31"}, l31, 19);
        chk({name, "_exch31"}, e31, 0);
        chk({name, "_cnt0"}, cnt0, cnt_model);
        chk({name, "_cnt31"}, cnt31, 0);
    endtask

    vec_t tbl[9];

    initial begin
        int l0, l31, nd;
        logic e0, e31;
        vec_t v;

        tbl[0] = '{24'd100, 24'd40, 1'b0, 17'h08000, 24'd0, 1'b1};
        tbl[1] = '{24'd40, 24'd100, 1'b0, 17'h10000, 24'(59 << 16), 1'b0};
        tbl[2] = '{24'd40, 24'd100, 1'b0, 17'h10000, 24'(60 << 16), 1'b1};
        tbl[3] = '{24'd500, 24'd500, 1'b1, 17'h1FFFF, 24'd0, 1'b1};
        tbl[4] = '{24'd0, 24'hFFFFFF, 1'b0, 17'h00000, 24'd0, 1'b1};
        tbl[5] = '{24'd10, 24'd20, 1'b1, 17'h10000, 24'd0, 1'b1};
        tbl[6] = '{24'hFFFFFF, 24'd0, 1'b1, 17'h1FFFF, 24'hFFFFFF, 1'b0};
        tbl[7] = '{24'd0, 24'd1, 1'b0, 17'h00001, 24'd0, 1'b0};
        tbl[8] = '{24'd0, 24'd1, 1'b0, 17'h00001, 24'd1, 1'b1};

        // Reset values while reset is held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_exch", exchange0, 0);
        chk("rst_cnt", cnt0, 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed vectors
        for (int i = 0; i < 9; i++) begin
            run_check($sformatf("vec%0d", i), tbl[i]);
        end

        // Start held for three cycles gives exactly one result
        run(tbl[0], 3, l0, e0, nd, l31, e31);
        cnt_model = sat(cnt_model + 1);
        chk("hold3_ndone", nd, 1);
        chk("hold3_cnt", cnt0, cnt_model);

        // Abort in IDLE clears a held exchange
        chk("held_exch", exchange0, 1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort_exch", exchange0, 0);

        // Abort mid-test
        @(negedge clk);
        apply(tbl[0]);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n < 5; n++) begin @(posedge clk); #1; end
        chk("abort_busy_before", busy0, 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy_after", busy0, 0);
        nd = 0;
        for (int n = 0; n < 30; n++) begin @(posedge clk); #1; nd += int'(done0); end
        chk("abort_ndone", nd, 0);
        chk("abort_exch", exchange0, 0);
        chk("abort_cnt", cnt0, cnt_model);

        // Start and abort together: nothing starts
        @(negedge clk);
        apply(tbl[0]);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        chk("race_busy", busy0, 0);
        nd = 0;
        for (int n = 0; n < 25; n++) begin @(posedge clk); #1; nd += int'(done0); end
        chk("race_ndone", nd, 0);

        // Clear on the edge that delivers an accepting result
        @(negedge clk);
        apply(tbl[0]);
        start = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (n == 0) start = 1'b0;
            if (n == 18) cnt_clr = 1'b1;
            if (n == 19) begin
                chk("clr_done", done0, 1);
                chk("clr_cnt", cnt0, 0);
                cnt_clr = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("clr_cnt_after", cnt0, 0);
        cnt_model = 0;

        // Saturation from 16'hFFFE
        @(negedge clk);
        force dut0.cnt_q = 16'hFFFE;
        #1;
        release dut0.cnt_q;
        cnt_model = 65534;
        for (int k = 0; k < 3; k++) run_check($sformatf("sat%0d", k), tbl[0]);
        chk("sat_final", cnt0, 16'hFFFF);

        // Reset asserted mid-MUL
        @(negedge clk);
        apply(tbl[0]);
        start = 1'b1;
        for (int n = 0; n < 8; n++) begin @(posedge clk); #1; if (n == 0) start = 1'b0; end
        chk("mid_busy_before", busy0, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy0, 0);
        chk("mid_rst_done", done0, 0);
        chk("mid_rst_exch", exchange0, 0);
        chk("mid_rst_cnt", cnt0, 0);
        cnt_model = 0;
        @(negedge clk);
        reset = 1'b1;
        nd = 0;
        for (int n = 0; n < 30; n++) begin @(posedge clk); #1; nd += int'(done0); end
        chk("mid_rst_ndone", nd, 0);

        // Randomized vectors against the model
        for (int i = 0; i < 30; i++) begin
            v.self_e = 24'($urandom);
            v.neg    = 1'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                v.folw_e = v.self_e + 24'($urandom_range(0, 200)) - 24'd100;
                v.mag    = 17'($urandom_range(0, 255));
                v.rnd    = 24'($urandom_range(0, 20000));
            end else begin
                v.folw_e = 24'($urandom);
                v.mag    = 17'($urandom);
                v.rnd    = 24'($urandom);
            end
            v.exp = model(v, 1'b1);
            run_check($sformatf("rnd%0d", i), v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
